// File: rtl/io_opcode_sequencer.sv
// Burst sequencer that turns opcode+length commands into the registered io_opcode stream for io_decode.
// Optional performance counter of non-NOP beats is enabled with `define IO_SEQ_PERF_CNT_EN.

package periphery_pkg;
  localparam int IO_OPCODE_L = 3;
  typedef logic [IO_OPCODE_L-1:0] io_opcode_t;

  localparam io_opcode_t IO_OPCODE_NOP             = 3'd0;
  localparam io_opcode_t IO_OPCODE_RD_EN           = 3'd1;
  localparam io_opcode_t IO_OPCODE_WR_EN           = 3'd2;
  localparam io_opcode_t IO_OPCODE_CONFIG_SHIFT_EN = 3'd3;
  localparam io_opcode_t IO_OPCODE_MONITOR         = 3'd4;
  localparam io_opcode_t IO_OPCODE_REG_SHIFT_EN    = 3'd5;

  function automatic logic io_opcode_legal(input io_opcode_t op);
    return (op <= IO_OPCODE_REG_SHIFT_EN);
  endfunction
endpackage

module io_opcode_sequencer #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [periphery_pkg::IO_OPCODE_L-1:0] cmd_type,
  input  logic [LEN_W-1:0]                    cmd_len,
  input  logic                                io_stall,
  output logic [periphery_pkg::IO_OPCODE_L-1:0] io_opcode,
  output logic                                busy,
  output logic                                done,
  output logic                                cmd_err,
  output logic [CNT_W-1:0]                    perf_cnt
);
  import periphery_pkg::*;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] rem;
  io_opcode_t       type_q;
  logic             accept;
  logic             cmd_legal;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_legal = io_opcode_legal(cmd_type);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rem       <= '0;
      type_q    <= IO_OPCODE_NOP;
      io_opcode <= IO_OPCODE_NOP;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        S_IDLE: begin
          io_opcode <= IO_OPCODE_NOP;
          if (accept) begin
            if (cmd_legal && (cmd_len != '0)) begin
              io_opcode <= cmd_type;
              type_q    <= cmd_type;
              rem       <= cmd_len - LEN_W'(1);
              state     <= S_RUN;
            end else begin
              // Zero-length and illegal commands complete immediately without emitting anything.
              done    <= 1'b1;
              cmd_err <= ~cmd_legal;
            end
          end
        end
        default: begin
          if (rem == '0) begin
            io_opcode <= IO_OPCODE_NOP;
            done      <= 1'b1;
            state     <= S_IDLE;
          end else if (io_stall) begin
            io_opcode <= IO_OPCODE_NOP;
          end else begin
            io_opcode <= type_q;
            rem       <= rem - LEN_W'(1);
          end
        end
      endcase
    end
  end

`ifdef IO_SEQ_PERF_CNT_EN
  logic             load_non_nop;
  logic [CNT_W-1:0] perf_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    load_non_nop = 1'b0;
    if (state == S_IDLE)
      load_non_nop = accept && cmd_legal && (cmd_len != '0) && (cmd_type != IO_OPCODE_NOP);
    else
      load_non_nop = (rem != '0) && !io_stall && (type_q != IO_OPCODE_NOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_q <= '0;
    else if (load_non_nop && (perf_q != '1))
      perf_q <= perf_q + CNT_W'(1);
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_io_opcode_sequencer.sv
// Self-checking bench for io_opcode_sequencer: directed vector table, async-reset sequence,
// then randomized traffic against a burst-level reference model.

module tb_io_opcode_sequencer;
  import periphery_pkg::*;

  localparam int LEN_W = 16;
  localparam int CNT_W = 32;
`ifdef IO_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  io_opcode_t       cmd_type = IO_OPCODE_NOP;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             io_stall = 1'b0;
  io_opcode_t       io_opcode;
  logic             busy, done, cmd_err;
  logic [CNT_W-1:0] perf_cnt;

  int vectors = 0;
  int miscompares = 0;

  io_opcode_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .io_stall(io_stall),
    .io_opcode(io_opcode), .busy(busy), .done(done), .cmd_err(cmd_err),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pack_out(io_opcode_t op, logic d, logic e, logic b, logic r);
    return {op, d, e, b, r};
  endfunction

  task automatic apply(input logic v, input io_opcode_t t, input logic [LEN_W-1:0] l, input logic s);
    cmd_valid = v; cmd_type = t; cmd_len = l; io_stall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; io_stall = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Burst-level reference: tracks how many beats of the current burst have been emitted.
  bit         m_in_burst;
  io_opcode_t m_type, m_op;
  int         m_len, m_emitted;
  bit         m_done, m_err;
  longint     m_perf;

  function automatic void model_reset();
    m_in_burst = 0; m_type = IO_OPCODE_NOP; m_op = IO_OPCODE_NOP;
    m_len = 0; m_emitted = 0; m_done = 0; m_err = 0; m_perf = 0;
  endfunction

  function automatic void model_edge(bit v, io_opcode_t t, int l, bit s);
    bit legal = (t inside {IO_OPCODE_NOP, IO_OPCODE_RD_EN, IO_OPCODE_WR_EN,
                           IO_OPCODE_CONFIG_SHIFT_EN, IO_OPCODE_MONITOR, IO_OPCODE_REG_SHIFT_EN});
    m_done = 0; m_err = 0; m_op = IO_OPCODE_NOP;
    if (!m_in_burst) begin
      if (v) begin
        if (legal && l > 0) begin
          m_in_burst = 1; m_type = t; m_len = l; m_emitted = 1; m_op = t;
        end else begin
          m_done = 1; m_err = !legal;
        end
      end
    end else if (m_emitted == m_len) begin
      m_done = 1; m_in_burst = 0;
    end else if (!s) begin
      m_op = m_type; m_emitted++;
    end
    if (PERF_EN && m_op != IO_OPCODE_NOP && m_perf < 64'hFFFF_FFFF) m_perf++;
  endfunction

  typedef struct {
    logic       v;
    io_opcode_t t;
    int         l;
    logic       s;
    io_opcode_t op;
    logic       d, e, b, r;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, io_opcode_t t, int l, logic s,
                              io_opcode_t op, logic d, logic e, logic b, logic r);
    vec_t x;
    x.v = v; x.t = t; x.l = l; x.s = s; x.op = op; x.d = d; x.e = e; x.b = b; x.r = r;
    tbl.push_back(x);
  endfunction

  initial begin
    io_opcode_t cfg = IO_OPCODE_CONFIG_SHIFT_EN, rd = IO_OPCODE_RD_EN, wr = IO_OPCODE_WR_EN;
    io_opcode_t nop = IO_OPCODE_NOP, mon = IO_OPCODE_MONITOR, rsh = IO_OPCODE_REG_SHIFT_EN;
    io_opcode_t bad = 3'd7;

    // CONFIG_SHIFT_EN len=3
    add(1, cfg, 3, 0, cfg, 0, 0, 1, 0);
    add(0, nop, 0, 0, cfg, 0, 0, 1, 0);
    add(0, nop, 0, 0, cfg, 0, 0, 1, 0);
    add(0, nop, 0, 0, nop, 1, 0, 0, 1);
    // RD_EN len=4 with one stall cycle
    add(1, rd, 4, 0, rd,  0, 0, 1, 0);
    add(0, nop, 0, 0, rd,  0, 0, 1, 0);
    add(0, nop, 0, 1, nop, 0, 0, 1, 0);
    add(0, nop, 0, 0, rd,  0, 0, 1, 0);
    add(0, nop, 0, 0, rd,  0, 0, 1, 0);
    add(0, nop, 0, 0, nop, 1, 0, 0, 1);
    // WR_EN len=2 then RD_EN len=1 held valid: one NOP gap between them
    add(1, wr, 2, 0, wr,  0, 0, 1, 0);
    add(1, rd, 1, 0, wr,  0, 0, 1, 0);
    add(1, rd, 1, 0, nop, 1, 0, 0, 1);
    add(1, rd, 1, 0, rd,  0, 0, 1, 0);
    add(0, nop, 0, 0, nop, 1, 0, 0, 1);
    // zero length and illegal opcode
    add(1, rd, 0, 0, nop, 1, 0, 0, 1);
    add(1, bad, 5, 0, nop, 1, 1, 0, 1);
    add(0, nop, 0, 0, nop, 0, 0, 0, 1);
    // NOP len=7 timed idle
    add(1, nop, 7, 0, nop, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) add(0, nop, 0, 0, nop, 0, 0, 1, 0);
    add(0, nop, 0, 0, nop, 1, 0, 0, 1);

    do_reset();
    check("reset_outputs", pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
          pack_out(nop, 0, 0, 0, 1));
    check("reset_perf", perf_cnt, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].t, LEN_W'(tbl[i].l), tbl[i].s);
      check($sformatf("vec[%0d]", i), pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
            pack_out(tbl[i].op, tbl[i].d, tbl[i].e, tbl[i].b, tbl[i].r));
    end
    check("perf_after_table", perf_cnt, PERF_EN ? 10 : 0);

    // Mid-burst asynchronous reset after the 5th REG_SHIFT_EN beat
    apply(1, rsh, 10, 0);
    for (int i = 0; i < 4; i++) apply(0, nop, 0, 0);
    check("rsh_5th_beat", io_opcode, rsh);
    #2 rst = 1'b0;
    #1;
    check("abort_outputs", pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
          pack_out(nop, 0, 0, 0, 1));
    check("abort_perf", perf_cnt, 0);
    @(posedge clk);
    #1;
    check("abort_no_done", {done, busy}, 2'b00);
    #2 rst = 1'b1;
    apply(1, mon, 1, 0);
    check("mon_beat", pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
          pack_out(mon, 0, 0, 1, 0));
    apply(0, nop, 0, 0);
    check("mon_done", pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
          pack_out(nop, 1, 0, 0, 1));
    check("mon_perf", perf_cnt, PERF_EN ? 1 : 0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic       v = ($urandom_range(0, 1) == 1);
      io_opcode_t t = io_opcode_t'($urandom_range(0, 7));
      int         l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      logic       s = ($urandom_range(0, 3) == 0);
      model_edge(v && !m_in_burst, t, l, s);
      apply(v, t, LEN_W'(l), s);
      check($sformatf("rand[%0d]", c), pack_out(io_opcode, done, cmd_err, busy, cmd_ready),
            pack_out(m_op, m_done, m_err, m_in_burst, !m_in_burst));
      check($sformatf("rand_perf[%0d]", c), perf_cnt, m_perf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
